regfile_sb: RTL and testbench

Parametrised register file for the pipelined core. It adds per-register pending-write scoreboarding to the two-read/one-write, write-bypassed array:
- Decode marks a destination busy at issue.
- Writeback stores the result and retires the pending write.
- Read ports return bypassed data together with a busy flag, which the hazard unit turns into a stall.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_pend_cnt.sv | 41 ++++
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file: geometry of the
// array and the width of each per-register pending-write counter.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int PEND_W_DEF = 2;

    typedef logic [PEND_W_DEF-1:0] pendCnt_t;

endpackage

// File: rtl/regfile_pend_cnt.sv
// One saturating up/down pending-write counter. An increment and a
// decrement in the same cycle cancel; the count never wraps past either end.
module regfile_pend_cnt #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              at_max,
    output logic              nonzero,
    output logic              nextNonzero
);

    logic [PEND_W-1:0] nextCount;

    // Next count: step only when exactly one of inc/dec is asserted and the
    // step would not run past the all-ones ceiling or the zero floor.
    always_comb begin
        at_max    = (count == {PEND_W{1'b1}});
        nonzero   = (count != '0);
        nextCount = count;
        if (inc && !dec && !at_max) begin
            nextCount = count + PEND_W'(1);
        end else if (dec && !inc && nonzero) begin
            nextCount = count - PEND_W'(1);
        end
        nextNonzero = (nextCount != '0);
    end

    // Counter register, cleared asynchronously so in-flight writes are forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with write bypass and per-register
// pending-write scoreboarding for the hazard unit.
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              SrcBusy1,
    output logic              SrcBusy2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueDst,
    output logic              IssueReady,
    input  logic              WriteReg,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [ADDR_W:0]   PendCount,
    output logic              Underflow
);

    localparam int DEPTH = 2**ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZeroRegEn = 1'b1;
`else
    localparam bit ZeroRegEn = 1'b0;
`endif

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [PEND_W-1:0] cntVal [DEPTH];
    logic [DEPTH-1:0]  atMax;
    logic [DEPTH-1:0]  nonZero;
    logic [DEPTH-1:0]  nextNonZero;
    logic [DEPTH-1:0]  incVec;
    logic [DEPTH-1:0]  decVec;
    logic              issueAccept;
    logic              underflowHit;
    logic              memWe;
    logic [ADDR_W:0]   popNext;

    // Issue handshake: a full counter can still accept when the same
    // register retires a write this cycle, since the net change is zero.
    always_comb begin
        IssueReady   = !atMax[IssueDst]
                     || (WriteReg && (DstReg == IssueDst))
                     || (ZeroRegEn && (IssueDst == '0));
        issueAccept  = IssueValid && IssueReady;
        memWe        = WriteReg && !(ZeroRegEn && (DstReg == '0));
        underflowHit = memWe && !nonZero[DstReg];
    end

    // One pending counter per register; a hardwired zero register never counts.
    for (genvar i = 0; i < DEPTH; i++) begin : gCnt
        localparam logic [ADDR_W-1:0] IDX  = ADDR_W'(i);
        localparam bit                HARD = ZeroRegEn && (i == 0);

        assign incVec[i] = !HARD && issueAccept && (IssueDst == IDX);
        assign decVec[i] = !HARD && WriteReg && (DstReg == IDX);

        regfile_pend_cnt #(.PEND_W(PEND_W)) uCnt (
            .clk         (clk),
            .rst         (rst),
            .inc         (incVec[i]),
            .dec         (decVec[i]),
            .count       (cntVal[i]),
            .at_max      (atMax[i]),
            .nonzero     (nonZero[i]),
            .nextNonzero (nextNonZero[i])
        );
    end

    // Read ports: bypass the in-flight writeback, and report busy unless this
    // writeback retires the last pending write of the addressed register.
    always_comb begin
        SrcData1 = mem[SrcReg1];
        if (WriteReg && (DstReg == SrcReg1)) SrcData1 = DstData;
        if (ZeroRegEn && (SrcReg1 == '0))    SrcData1 = '0;
        SrcData2 = mem[SrcReg2];
        if (WriteReg && (DstReg == SrcReg2)) SrcData2 = DstData;
        if (ZeroRegEn && (SrcReg2 == '0))    SrcData2 = '0;
        SrcBusy1 = nonZero[SrcReg1]
                 && !(WriteReg && (DstReg == SrcReg1) && (cntVal[SrcReg1] == PEND_W'(1)));
        SrcBusy2 = nonZero[SrcReg2]
                 && !(WriteReg && (DstReg == SrcReg2) && (cntVal[SrcReg2] == PEND_W'(1)));
    end

    // Population count of the counters as they will be after this edge.
    always_comb begin
        popNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            popNext = popNext + (ADDR_W+1)'(nextNonZero[i]);
        end
    end

    // Register array, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (memWe) begin
            mem[DstReg] <= DstData;
        end
    end

    // Pending-register count and sticky underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PendCount <= '0;
            Underflow <= 1'b0;
        end else begin
            PendCount <= popNext;
            if (underflowHit) Underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, IssueDst, DstReg;
    logic [15:0] SrcData1, SrcData2, DstData;
    logic        SrcBusy1, SrcBusy2, IssueValid, IssueReady, WriteReg, Underflow;
    logic [4:0]  PendCount;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expEntry_t;

    expEntry_t expQ[$];
    int nChecks = 0;
    int nErrors = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .SrcReg1    (SrcReg1),
        .SrcReg2    (SrcReg2),
        .SrcData1   (SrcData1),
        .SrcData2   (SrcData2),
        .SrcBusy1   (SrcBusy1),
        .SrcBusy2   (SrcBusy2),
        .IssueValid (IssueValid),
        .IssueDst   (IssueDst),
        .IssueReady (IssueReady),
        .WriteReg   (WriteReg),
        .DstReg     (DstReg),
        .DstData    (DstData),
        .PendCount  (PendCount),
        .Underflow  (Underflow)
    );

    always #5 clk = ~clk;

    // Commit the previous step on a rising edge, then drive the new inputs.
    task automatic applyStimulus(input logic iv, input logic [3:0] id,
                                 input logic wr, input logic [3:0] dr,
                                 input logic [15:0] dd,
                                 input logic [3:0] s1, input logic [3:0] s2);
        @(posedge clk);
        #1;
        IssueValid = iv;
        IssueDst   = id;
        WriteReg   = wr;
        DstReg     = dr;
        DstData    = dd;
        SrcReg1    = s1;
        SrcReg2    = s2;
        #1;
    endtask

    task automatic pushExp(input string tag, input logic [31:0] value);
        expEntry_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expEntry_t e;
        nChecks++;
        if (expQ.size() == 0) begin
            nErrors++;
            $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=none", observed);
        end else begin
            e = expQ.pop_front();
            assert (observed === e.value) else begin
                nErrors++;
                $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, observed, e.value);
            end
        end
    endtask

    initial begin
        pendCnt_t maxCnt;
        maxCnt = '1;
        $display("[TB] start, max pending per register = %0d", maxCnt);

        rst = 1'b1; IssueValid = 1'b0; IssueDst = 4'd0;
        WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h0055;
        SrcReg1 = 4'd3; SrcReg2 = 4'd1;
        #2;
        pushExp("rst_bypass", 32'h0055);  checkOutput(32'(SrcData1));
        pushExp("rst_data2", 32'h0);      checkOutput(32'(SrcData2));
        pushExp("rst_busy1", 32'h0);      checkOutput(32'(SrcBusy1));
        pushExp("rst_ready", 32'h1);      checkOutput(32'(IssueReady));
        pushExp("rst_pend", 32'h0);       checkOutput(32'(PendCount));
        pushExp("rst_underflow", 32'h0);  checkOutput(32'(Underflow));
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        rst = 1'b0;

        applyStimulus(1, 4'd3, 0, 4'd0, 16'h0, 4'd3, 4'd0);
        pushExp("issue_r3_ready", 32'h1); checkOutput(32'(IssueReady));
        applyStimulus(0, 4'd0, 1, 4'd3, 16'h1234, 4'd3, 4'd0);
        pushExp("wr_r3_bypass", 32'h1234); checkOutput(32'(SrcData1));
        pushExp("wr_r3_busy", 32'h0);      checkOutput(32'(SrcBusy1));
        pushExp("wr_r3_pend", 32'h1);      checkOutput(32'(PendCount));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd3, 4'd0);
        pushExp("rd_r3_data", 32'h1234);  checkOutput(32'(SrcData1));
        pushExp("rd_r3_busy", 32'h0);     checkOutput(32'(SrcBusy1));
        pushExp("rd_r3_pend", 32'h0);     checkOutput(32'(PendCount));
        pushExp("rd_r3_underflow", 32'h0); checkOutput(32'(Underflow));

        applyStimulus(1, 4'd5, 0, 4'd0, 16'h0, 4'd5, 4'd0);
        pushExp("issue_r5_busy_same", 32'h0); checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd5, 4'd3);
        pushExp("r5_busy", 32'h1);        checkOutput(32'(SrcBusy1));
        pushExp("r5_pend", 32'h1);        checkOutput(32'(PendCount));
        pushExp("port2_r3", 32'h1234);    checkOutput(32'(SrcData2));
        applyStimulus(0, 4'd0, 1, 4'd5, 16'hBEEF, 4'd5, 4'd0);
        pushExp("wb_r5_bypass", 32'hBEEF); checkOutput(32'(SrcData1));
        pushExp("wb_r5_busy", 32'h0);      checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd5, 4'd0);
        pushExp("after_r5_pend", 32'h0);   checkOutput(32'(PendCount));
        pushExp("after_r5_data", 32'hBEEF); checkOutput(32'(SrcData1));

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 4'd7, 0, 4'd0, 16'h0, 4'd7, 4'd0);
            pushExp($sformatf("r7_ready_%0d", k), 32'h1); checkOutput(32'(IssueReady));
        end
        applyStimulus(1, 4'd7, 0, 4'd0, 16'h0, 4'd7, 4'd0);
        pushExp("r7_full_ready", 32'h0);  checkOutput(32'(IssueReady));
        pushExp("r7_full_busy", 32'h1);   checkOutput(32'(SrcBusy1));
        applyStimulus(1, 4'd7, 1, 4'd7, 16'h0777, 4'd7, 4'd0);
        pushExp("r7_net0_ready", 32'h1);  checkOutput(32'(IssueReady));
        pushExp("r7_net0_busy", 32'h1);   checkOutput(32'(SrcBusy1));
        pushExp("r7_net0_bypass", 32'h0777); checkOutput(32'(SrcData1));
        applyStimulus(0, 4'd7, 0, 4'd0, 16'h0, 4'd7, 4'd0);
        pushExp("r7_still_full", 32'h0);  checkOutput(32'(IssueReady));
        pushExp("r7_pend", 32'h1);        checkOutput(32'(PendCount));
        pushExp("r7_no_underflow", 32'h0); checkOutput(32'(Underflow));
        applyStimulus(0, 4'd0, 1, 4'd7, 16'h0701, 4'd7, 4'd0);
        pushExp("r7_drain3_busy", 32'h1); checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 1, 4'd7, 16'h0702, 4'd7, 4'd0);
        pushExp("r7_drain2_busy", 32'h1); checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 1, 4'd7, 16'h0703, 4'd7, 4'd0);
        pushExp("r7_drain1_busy", 32'h0); checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd7, 4'd0);
        pushExp("r7_empty_pend", 32'h0);  checkOutput(32'(PendCount));
        pushExp("r7_empty_data", 32'h0703); checkOutput(32'(SrcData1));
        pushExp("r7_empty_underflow", 32'h0); checkOutput(32'(Underflow));

        applyStimulus(0, 4'd0, 1, 4'd9, 16'h9999, 4'd9, 4'd0);
        pushExp("uf_pre_flag", 32'h0);    checkOutput(32'(Underflow));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd9, 4'd0);
        pushExp("uf_data", 32'h9999);     checkOutput(32'(SrcData1));
        pushExp("uf_flag", 32'h1);        checkOutput(32'(Underflow));
        pushExp("uf_pend", 32'h0);        checkOutput(32'(PendCount));
        applyStimulus(0, 4'd0, 1, 4'd2, 16'h2222, 4'd0, 4'd0);
        applyStimulus(1, 4'd2, 0, 4'd0, 16'h0, 4'd0, 4'd0);
        pushExp("uf_sticky", 32'h1);      checkOutput(32'(Underflow));
        applyStimulus(1, 4'd4, 0, 4'd0, 16'h0, 4'd2, 4'd0);
        pushExp("r2_busy", 32'h1);        checkOutput(32'(SrcBusy1));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd2, 4'd4);
        pushExp("r2r4_pend", 32'h2);      checkOutput(32'(PendCount));
        pushExp("r4_busy", 32'h1);        checkOutput(32'(SrcBusy2));
        pushExp("r2_data", 32'h2222);     checkOutput(32'(SrcData1));

        rst = 1'b1;
        IssueValid = 1'b1; IssueDst = 4'd4;
        WriteReg = 1'b1; DstReg = 4'd8; DstData = 16'h8888; SrcReg2 = 4'd8;
        #1;
        pushExp("mid_rst_busy1", 32'h0);  checkOutput(32'(SrcBusy1));
        pushExp("mid_rst_data1", 32'h0);  checkOutput(32'(SrcData1));
        pushExp("mid_rst_bypass2", 32'h8888); checkOutput(32'(SrcData2));
        pushExp("mid_rst_pend", 32'h0);   checkOutput(32'(PendCount));
        pushExp("mid_rst_underflow", 32'h0); checkOutput(32'(Underflow));
        pushExp("mid_rst_ready", 32'h1);  checkOutput(32'(IssueReady));
        repeat (2) @(posedge clk);
        #1;
        pushExp("held_rst_pend", 32'h0);  checkOutput(32'(PendCount));
        pushExp("held_rst_busy2", 32'h0); checkOutput(32'(SrcBusy2));
        IssueValid = 1'b0; WriteReg = 1'b0;
        rst = 1'b0;
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd2, 4'd8);
        pushExp("post_rst_r2_data", 32'h0); checkOutput(32'(SrcData1));
        pushExp("post_rst_r2_busy", 32'h0); checkOutput(32'(SrcBusy1));
        pushExp("post_rst_r8_data", 32'h0); checkOutput(32'(SrcData2));
        pushExp("post_rst_pend", 32'h0);    checkOutput(32'(PendCount));

        applyStimulus(1, 4'd0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
`ifdef REGFILE_ZERO_REG_EN
        pushExp("r0_wr_data", 32'h0);     checkOutput(32'(SrcData1));
        pushExp("r0_wr_ready", 32'h1);    checkOutput(32'(IssueReady));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd0, 4'd0);
        pushExp("r0_data", 32'h0);        checkOutput(32'(SrcData1));
        pushExp("r0_busy", 32'h0);        checkOutput(32'(SrcBusy1));
        pushExp("r0_pend", 32'h0);        checkOutput(32'(PendCount));
        pushExp("r0_underflow", 32'h0);   checkOutput(32'(Underflow));
`else
        pushExp("r0_wr_data", 32'hFFFF);  checkOutput(32'(SrcData1));
        pushExp("r0_wr_ready", 32'h1);    checkOutput(32'(IssueReady));
        applyStimulus(0, 4'd0, 0, 4'd0, 16'h0, 4'd0, 4'd0);
        pushExp("r0_data", 32'hFFFF);     checkOutput(32'(SrcData1));
        pushExp("r0_busy", 32'h0);        checkOutput(32'(SrcBusy1));
        pushExp("r0_pend", 32'h0);        checkOutput(32'(PendCount));
        pushExp("r0_underflow", 32'h1);   checkOutput(32'(Underflow));
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
